// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit, one bit per clock.
//   op 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
//   Operands are captured on the accepted start edge. The unit runs WIDTH
//   shift-add / shift-subtract iterations, then applies the sign fix-up in
//   FINISH. done pulses for one cycle, WIDTH+1 cycles after the start edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op, a, b   request (start is sampled only while busy=0)
//   busy              operation in flight
//   done              one-cycle pulse; hi/lo are valid
//   hi, lo            product {hi,lo}, or remainder (hi) and quotient (lo)
//   div_by_zero       last completed op was a divide with b=0
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state;
    logic               is_div;
    logic               b_zero;
    logic               neg_res;   // negate product / quotient
    logic               neg_rem;   // negate remainder
    logic [WIDTH-1:0]   a_r;       // raw dividend, returned on divide by zero
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;      // mult: {acc, multiplier}; div: {rem, quot}
    logic [CW-1:0]      cnt;

    // Operand magnitudes; op[0]=0 selects the signed variants.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of each datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        // Add multiplicand into the upper half when the current multiplier
        // bit is set, then shift the whole register right (carry included).
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_b} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        // Restoring divide: shift {rem,quot} left, try subtracting divisor.
        // Bit WIDTH of the trial is the borrow (partial remainder < divisor).
        div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, mag_b};
        div_next  = div_trial[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end

    // Sign fix-up applied at FINISH.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod_fix = neg_res ? (~prod + 1'b1) : prod;
        if (!is_div) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
            fin_hi = a_r;
            fin_lo = '1;
        end else begin
            fin_hi = neg_rem ? (~prod[2*WIDTH-1:WIDTH] + 1'b1) : prod[2*WIDTH-1:WIDTH];
            fin_lo = neg_res ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            a_r         <= '0;
            mag_b       <= '0;
            prod        <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        is_div      <= op[1];
                        b_zero      <= (b == '0);
                        neg_res     <= a_neg ^ b_neg;
                        neg_rem     <= a_neg;
                        a_r         <= a;
                        mag_b       <= op[1] ? b_mag : a_mag;
                        // Multiply keeps the multiplier in the low half and
                        // adds the multiplicand; divide shifts the dividend out.
                        prod        <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                        cnt         <= '0;
                    end
                end
                RUN: begin
                    prod <= is_div ? div_next : mul_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FINISH;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    hi          <= fin_hi;
                    lo          <= fin_lo;
                    div_by_zero <= is_div & b_zero;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values. Returns {dbz, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = 64'(sx * sy); return {1'b0, p}; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    sq = sx / sy;   // truncates toward zero
                    sr = sx % sy;   // takes the dividend's sign
                    return {1'b0, 32'(sr), 32'(sq)};
                end
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Drive a request now; it is accepted on the next rising edge. Waits for
    // done (bounded), checks latency, busy, hold behaviour and results.
    // Returns #1 after the edge that raised done, so a follow-on call issues
    // its start inside the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [64:0] exp;
        logic [31:0] hi0, lo0;
        int          cyc;
        bit          got;
        exp = model(o, x, y);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y; op = ~o;   // later input changes must not matter
        chk({tag, ".busy_rise"}, 64'(busy), 64'd1);
        chk({tag, ".done_low"}, 64'(done), 64'd0);
        chk({tag, ".dbz_clr"}, 64'(div_by_zero), 64'd0);
        got = 0; cyc = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            cyc = i;
            if (i == 16) chk({tag, ".hold"}, {hi, lo}, {hi0, lo0});
            if (done) got = 1;
        end
        chk({tag, ".done_seen"}, 64'(got), 64'd1);
        chk({tag, ".latency"}, 64'(cyc), 64'd33);
        chk({tag, ".busy_fall"}, 64'(busy), 64'd0);
        chk({tag, ".hilo"}, {hi, lo}, exp[63:0]);
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp[64]));
    endtask

    initial begin
        int ndone, dcyc;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #3;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        chk("rst.dbz", 64'(div_by_zero), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_b2b", 2'b10, 32'hFFFF_FFF9, 32'd2);   // issued in the done cycle
        chk("div_b2b.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0);
        chk("divu_zero.const", {div_by_zero, hi, lo}, {1'b0, 64'h0000_0005_FFFF_FFFF} | (65'd1 << 64));
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FF00, 32'd0);

        // Starts while busy are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5 || i == 20) begin
                start = 1'b1; op = 2'b00; a = 32'd99; b = 32'd77;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin ndone++; dcyc = i; end
        end
        start = 1'b0;
        chk("ignore.ndone", 64'(ndone), 64'd1);
        chk("ignore.cycle", 64'(dcyc), 64'd33);
        chk("ignore.hilo", {hi, lo}, 64'd12);
        chk("ignore.busy", 64'(busy), 64'd0);

        // Randomized operations, some back to back
        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            run_op($sformatf("rnd%0d", n), ro, ra, rb);
        end

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.hilo", {hi, lo}, 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'd0);

        // First start after release is accepted normally
        @(negedge clk);
        run_op("post_rst", 2'b10, 32'hFFFF_FF9C, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
